// File: rtl/blink_rx.sv
// Blink receiver: measures led_in half-periods against 2**CBITS and tracks lock.
// Optional concurrent checks compile in when BLINK_RX_ASSERT_EN is defined.
module blink_rx #(
    parameter int CBITS    = 9,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    output logic             edge_o,
    output logic             err_o,
    output logic             locked,
    output logic             phase_o,
    output logic [CBITS+1:0] interval_o
);
    localparam int W = CBITS + 2;
    localparam logic [W-1:0] HALF    = W'(1) << CBITS;
    localparam logic [W-1:0] HALF_LO = HALF - W'(TOL);
    localparam logic [W-1:0] HALF_HI = HALF + W'(TOL);
    localparam logic [3:0]   LOCK_N  = 4'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t         state;
    logic           led_q;
    logic [W-1:0]   run;
    logic [3:0]     good_cnt;

    logic           edge_det;
    logic [W-1:0]   interval;
    logic [W-1:0]   run_next;
    logic           good;
    logic           timeout;

    assign edge_det = led_in ^ led_q;
    assign interval = run + W'(1);
    assign good     = (interval >= HALF_LO) && (interval <= HALF_HI);
    // An edge landing exactly at HALF+TOL wins over the timeout.
    assign timeout  = (state != IDLE) && (run == HALF_HI) && !edge_det;
    assign run_next = edge_det ? '0 : ((&run) ? run : run + W'(1));

    // NOTE: every register here uses <= so all reads see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            led_q      <= 1'b0;
            run        <= '0;
            good_cnt   <= '0;
            edge_o     <= 1'b0;
            err_o      <= 1'b0;
            locked     <= 1'b0;
            phase_o    <= 1'b0;
            interval_o <= '0;
        end else begin
            led_q  <= led_in;
            edge_o <= edge_det;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    run <= '0;
                    if (edge_det) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    run <= run_next;
                    if (edge_det) begin
                        interval_o <= interval;
                        phase_o    <= led_in;
                        if (good) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            err_o    <= 1'b1;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        err_o    <= 1'b1;
                        state    <= IDLE;
                        run      <= '0;
                        good_cnt <= '0;
                    end
                end
                LOCK: begin
                    run <= run_next;
                    if (edge_det) begin
                        interval_o <= interval;
                        phase_o    <= led_in;
                        if (!good) begin
                            err_o    <= 1'b1;
                            state    <= ACQ;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        err_o    <= 1'b1;
                        state    <= IDLE;
                        locked   <= 1'b0;
                        run      <= '0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    run    <= '0;
                end
            endcase
        end
    end

`ifdef BLINK_RX_ASSERT_EN
    a_err_unlocks: assert property (@(posedge clk) disable iff (rst)
        err_o |=> (!locked || edge_o));
    // A timeout error (no edge alongside) can never repeat on the next cycle.
    a_timeout_single: assert property (@(posedge clk) disable iff (rst)
        (err_o && !edge_o) |=> !(err_o && !edge_o));
    a_lock_live: assert property (@(posedge clk) disable iff (rst)
        locked |-> s_eventually (edge_o || err_o));
    a_lock_on_edge: assert property (@(posedge clk) disable iff (rst)
        $rose(locked) |-> edge_o);
`else
    // Checks disabled: the datapath above is identical either way.
`endif

endmodule
